limber_gnrl_pipe_dffr: RTL
==========================

LIMBER_GNRL_PIPE_DFFR -- requirements
Module: limber_gnrl_pipe_dffr

Interface
REQ-001 Parameter DW, default 8: data width in bits; legal range 1..1024.
REQ-002 Parameter STAGES, default 2: number of register stages; legal range 1..16.
REQ-003 Parameter CW, default $clog2(STAGES+1): width of the occupancy count.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port flush, input, 1 bit: synchronous clear of all stage valids.
REQ-007 Port i_valid, input, 1 bit: upstream offers i_data this cycle.
REQ-008 Port i_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-009 Port i_data, input, DW bits: upstream payload.
REQ-010 Port o_valid, output, 1 bit: last stage holds valid data.
REQ-011 Port o_ready, input, 1 bit: downstream accepts this cycle.
REQ-012 Port o_data, output, DW bits: payload held in the last stage.
REQ-013 Port count, output, CW bits: number of valid stages.

Function
REQ-014 Each stage k shall hold one valid bit v[k] and one DW-bit data register d[k]; stage 0 faces the input and stage STAGES-1 faces the output.
REQ-015 Stage readiness shall be defined as rdy[STAGES-1] = !v[STAGES-1] | o_ready, and rdy[k] = !v[k] | rdy[k+1] for k < STAGES-1; this is a combinational bubble-collapsing chain.
REQ-016 i_ready shall equal rdy[0] & !flush.
REQ-017 A transfer at the input shall occur on a cycle where i_valid & i_ready; a transfer at the output shall occur on a cycle where o_valid & o_ready.
REQ-018 When rdy[k] is high, stage k shall load from stage k-1, taking v[k-1] and d[k-1]; stage 0 loads i_valid & !flush and i_data.
REQ-019 When rdy[k] is low, stage k shall hold both its valid bit and its data.
REQ-020 A data register shall load only when its incoming valid is high, so that data is not toggled by bubbles.
REQ-021 o_valid shall equal v[STAGES-1] and o_data shall equal d[STAGES-1].
REQ-022 With o_ready held high, latency from input transfer to o_valid shall be exactly STAGES cycles, and throughput shall be one beat per cycle.
REQ-023 Under a stall (o_ready low), bubbles shall collapse: the pipe shall absorb up to STAGES beats before i_ready falls.
REQ-024 When all stages are full and o_ready is high, an input transfer and an output transfer shall occur in the same cycle and count shall be unchanged.
REQ-025 Data order shall be preserved; no beat shall be duplicated or dropped except by flush.
REQ-026 On flush, all v[k] shall clear on the next edge, no input shall be accepted, and d[k] contents are don't-care.
REQ-027 flush shall take priority over i_valid and o_ready.
REQ-028 o_valid may be high during a flush cycle, and an output transfer in that cycle is legal.
REQ-029 count shall be the registered population count of v and shall always lie in 0..STAGES.
REQ-030 With STAGES=1, the block shall behave as a one-entry buffer with i_ready = !v[0] | o_ready.

Reset
REQ-031 Assertion of rst shall immediately clear all v[k], all d[k], and count to zero, independent of clk.
REQ-032 While rst is asserted, the outputs shall be o_valid=0, o_data=0, count=0, and i_ready=1 (when flush is low).
REQ-033 Reset mid-transfer shall discard all in-flight beats, and the first post-reset accepted beat shall appear after STAGES cycles.
REQ-034 Deassertion of rst shall be synchronised externally and is not handled in this block.

Structure
REQ-035 The stage shall be a sub-module, limber_gnrl_pipe_stage (DW-parametrised valid+data register with load enable and async reset), instantiated STAGES times in a generate loop.
REQ-036 The DW and STAGES legal-range limits shall live in the shared limber_gnrl defines header, not locally.
REQ-037 No memories or latches shall be inferred; all state shall be flip-flops on clk/rst.

Verification
REQ-038 Streaming test: STAGES=3, o_ready=1, send 0x01..0x10 back-to-back -> o_data 0x01 appears on cycle 3, then one beat per cycle in order, and count stays at 3.
REQ-039 Stall/fill test: STAGES=3, o_ready=0, offer 5 beats -> 3 accepted, i_ready=0 thereafter, count=3; release o_ready -> 0xA,0xB,0xC emerge in order.
REQ-040 Bubble collapse test: STAGES=4, one beat then 2 idle cycles then a beat, with o_ready low -> both beats packed in stages 3 and 2, and count=2.
REQ-041 Flush test: full pipe with flush=1 and i_valid=1 for one cycle -> next cycle count=0, o_valid=0, and the offered beat is not accepted.
REQ-042 Async reset test: assert rst between clock edges with pipe full -> o_valid, o_data, and count are 0 before the next edge.
REQ-043 Random test: random i_valid/o_ready over 10k cycles for STAGES=1 and STAGES=16, checked against a scoreboard -> no loss, no duplication, and count equals the scoreboard depth.

Source files
------------

// File: rtl/limber_gnrl_pipe_dffr_pkg.sv
// Shared limits for the limber_gnrl pipe blocks.
// The pipe top checks its parameters against these at elaboration.
package limber_gnrl_pipe_dffr_pkg;
    localparam int DW_MIN     = 1;
    localparam int DW_MAX     = 1024;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 16;
endpackage

// File: rtl/limber_gnrl_pipe_stage.sv
// One pipe slot: a valid bit plus a DW-bit payload with load enable and async reset.
// The payload only loads when the incoming valid is set, so bubbles leave it untouched.
module limber_gnrl_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          v_in,
    input  logic [DW-1:0] d_in,
    output logic          v,
    output logic [DW-1:0] d
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
        end else if (load && v_in) begin
            d <= d_in;
        end
    end

endmodule

// File: rtl/limber_gnrl_pipe_dffr.sv
// Valid/ready register pipe of STAGES slots with bubble collapsing, flush and
// a registered occupancy count.
module limber_gnrl_pipe_dffr
    import limber_gnrl_pipe_dffr_pkg::*;
#(
    parameter int DW     = 8,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] count
);

    if (DW < DW_MIN || DW > DW_MAX) begin : g_bad_dw
        $error("limber_gnrl_pipe_dffr: DW out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("limber_gnrl_pipe_dffr: STAGES out of range");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] v_nxt;
    logic [DW-1:0]     d [STAGES];
    logic [CW-1:0]     cnt_q;

    function automatic logic [CW-1:0] popcnt(input logic [STAGES-1:0] x);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < STAGES; k++) begin
            n = n + CW'(x[k]);
        end
        return n;
    endfunction

    // A stage is ready if it is empty or everything downstream of it can move.
    always_comb begin
        logic r;
        r   = o_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !v[k] | r;
            rdy[k] = r;
        end
    end

    // Flush forces every stage to load a bubble, which also blocks the input.
    always_comb begin
        v_in    = '0;
        v_in[0] = i_valid & !flush;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v[k-1] & !flush;
        end
        ld    = rdy | {STAGES{flush}};
        v_nxt = (ld & v_in) | (~ld & v);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [DW-1:0] d_src;
        if (k == 0) begin : g_src_in
            assign d_src = i_data;
        end else begin : g_src_prev
            assign d_src = d[k-1];
        end

        limber_gnrl_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .load (ld[k]),
            .v_in (v_in[k]),
            .d_in (d_src),
            .v    (v[k]),
            .d    (d[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= popcnt(v_nxt);
        end
    end

    assign i_ready = rdy[0] & !flush;
    assign o_valid = v[STAGES-1];
    assign o_data  = d[STAGES-1];
    assign count   = cnt_q;

endmodule
